// File: rtl/tl_pkg.sv
// Shared lamp encodings and debounce state type for the country-road
// signal controller blocks.
package tl_pkg;

    localparam logic [2:0] LAMP_GREEN  = 3'b001;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_RED    = 3'b100;

    typedef enum logic [1:0] {
        DEB_IDLE,
        DEB_RISE_CHK,
        DEB_PRESENT,
        DEB_FALL_CHK
    } deb_state_e;

endpackage

// File: rtl/sensor_debounce.sv
// Loop-sensor synchroniser and debouncer. A level change is accepted only
// after DEB_CYCLES consecutive stable synchronised samples.
//   state    | meaning
//   IDLE     | loop empty, waiting for a synced high
//   RISE_CHK | counting stable highs before declaring a car
//   PRESENT  | car on the loop
//   FALL_CHK | counting stable lows before declaring the loop empty
module sensor_debounce
    import tl_pkg::*;
#(
    parameter int DEB_CYCLES = 8
) (
    input  logic clock,
    input  logic clear_n,
    input  logic sensor_raw_i,
    output logic presence_o,
    output logic presence_nxt_o,
    output logic arrive_o
);

    localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic       sync1_q, sync2_q;
    deb_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= DEB_IDLE;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sensor_raw_i;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        arrive_o = 1'b0;
        case (state_q)
            DEB_IDLE: begin
                if (sync2_q) begin
                    state_d = DEB_RISE_CHK;
                    cnt_d   = CNT_ONE;
                end
            end
            DEB_RISE_CHK: begin
                if (!sync2_q) begin
                    state_d = DEB_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = DEB_PRESENT;
                    cnt_d    = '0;
                    arrive_o = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DEB_PRESENT: begin
                if (!sync2_q) begin
                    state_d = DEB_FALL_CHK;
                    cnt_d   = CNT_ONE;
                end
            end
            DEB_FALL_CHK: begin
                if (sync2_q) begin
                    state_d = DEB_PRESENT;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DEB_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = DEB_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign presence_o     = (state_q == DEB_PRESENT) || (state_q == DEB_FALL_CHK);
    assign presence_nxt_o = (state_d == DEB_PRESENT) || (state_d == DEB_FALL_CHK);

endmodule

// File: rtl/country_car_detect.sv
// Country-road car-waiting request: debounced loop presence plus a queue of
// arrived cars drained one per PASS_CYCLES of country green.
module country_car_detect
    import tl_pkg::*;
#(
    parameter int DEB_CYCLES  = 8,
    parameter int PASS_CYCLES = 16,
    parameter int CNT_W       = 4
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             sensor_raw,
    input  logic [2:0]       crd,
    output logic             x,
    output logic             presence,
    output logic [CNT_W-1:0] car_count
);

    localparam int TW = (PASS_CYCLES > 2) ? $clog2(PASS_CYCLES) : 1;
    localparam logic [TW-1:0]    TMR_LAST = TW'(PASS_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic             presence_nxt, arrive, green, drain;
    logic [TW-1:0]    tmr_q, tmr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             x_q, x_d;

    sensor_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_debounce (
        .clock          (clock),
        .clear_n        (clear_n),
        .sensor_raw_i   (sensor_raw),
        .presence_o     (presence),
        .presence_nxt_o (presence_nxt),
        .arrive_o       (arrive)
    );

    // Illegal lamp codes simply fail the GREEN compare.
    assign green = (crd == LAMP_GREEN);
    assign drain = green && (count_q != '0) && (tmr_q == TMR_LAST);

    always_comb begin
        tmr_d = tmr_q;
        if (!green) begin
            tmr_d = '0;
        end else if (count_q != '0) begin
            tmr_d = drain ? '0 : tmr_q + 1'b1;
        end
    end

    always_comb begin
        count_d = count_q;
        case ({arrive, drain})
            2'b10:   if (count_q != CNT_MAX) count_d = count_q + 1'b1;
            2'b01:   if (count_q != '0)      count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        x_d = presence_nxt || (count_d != '0);
    end

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            tmr_q   <= '0;
            count_q <= '0;
            x_q     <= 1'b0;
        end else begin
            tmr_q   <= tmr_d;
            count_q <= count_d;
            x_q     <= x_d;
        end
    end

    assign x         = x_q;
    assign car_count = count_q;

endmodule

// File: tb/tb_country_car_detect.sv
// Directed bench for country_car_detect: expected outputs are queued with
// each stimulus step and popped against the DUT one clock-phase later.
module tb_country_car_detect;

    logic       clock = 1'b0;
    logic       clear_n;
    logic       sensor_raw;
    logic [2:0] crd;
    logic       x;
    logic       presence;
    logic [3:0] car_count;

    typedef struct {
        string      tag;
        logic       x;
        logic       pres;
        logic [3:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    country_car_detect #(
        .DEB_CYCLES (8),
        .PASS_CYCLES(16),
        .CNT_W      (4)
    ) dut (
        .clock     (clock),
        .clear_n   (clear_n),
        .sensor_raw(sensor_raw),
        .crd       (crd),
        .x         (x),
        .presence  (presence),
        .car_count (car_count)
    );

    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic push_exp(input string tag, input logic ex, input logic ep, input logic [3:0] ec);
        exp_t e;
        e.tag  = tag;
        e.x    = ex;
        e.pres = ep;
        e.cnt  = ec;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            n_total++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e = sb.pop_front();
        n_total++;
        assert (x === e.x) n_pass++;
        else $error("FAIL %s.x observed=%b expected=%b", e.tag, x, e.x);
        n_total++;
        assert (presence === e.pres) n_pass++;
        else $error("FAIL %s.presence observed=%b expected=%b", e.tag, presence, e.pres);
        n_total++;
        assert (car_count === e.cnt) n_pass++;
        else $error("FAIL %s.car_count observed=%0d expected=%0d", e.tag, car_count, e.cnt);
    endtask

    task automatic chk(input string tag, input logic ex, input logic ep, input logic [3:0] ec);
        push_exp(tag, ex, ep, ec);
        check_out();
    endtask

    // One clean car: on the loop long enough to debounce, then gone long enough to clear.
    task automatic car();
        sensor_raw = 1'b1;
        tick(12);
        sensor_raw = 1'b0;
        tick(12);
    endtask

    initial begin
        clear_n    = 1'b0;
        sensor_raw = 1'b1;
        crd        = 3'b100;

        // reset with the loop occupied
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk("reset", 1'b0, 1'b0, 4'd0);
        end
        sensor_raw = 1'b0;
        clear_n    = 1'b1;
        tick(3);
        chk("idle", 1'b0, 1'b0, 4'd0);

        // bounce: 5 highs, 1 low, never 8 stable highs
        for (int i = 0; i < 6; i++) begin
            sensor_raw = 1'b1;
            tick(5);
            sensor_raw = 1'b0;
            tick(1);
            chk("bounce", 1'b0, 1'b0, 4'd0);
        end
        tick(12);
        chk("bounce_end", 1'b0, 1'b0, 4'd0);

        // single car under RED, 2+8 clock lag on both edges
        sensor_raw = 1'b1;
        tick(9);
        chk("car_pre", 1'b0, 1'b0, 4'd0);
        tick(1);
        chk("car_edge", 1'b1, 1'b1, 4'd1);
        tick(10);
        sensor_raw = 1'b0;
        tick(9);
        chk("leave_pre", 1'b1, 1'b1, 4'd1);
        tick(1);
        chk("leave", 1'b1, 1'b0, 4'd1);

        // drain three cars at 16-clock intervals
        car();
        car();
        chk("queue3", 1'b1, 1'b0, 4'd3);
        crd = 3'b001;
        tick(15);
        chk("green_pre", 1'b1, 1'b0, 4'd3);
        tick(1);
        chk("drain1", 1'b1, 1'b0, 4'd2);
        tick(15);
        chk("drain2_pre", 1'b1, 1'b0, 4'd2);
        tick(1);
        chk("drain2", 1'b1, 1'b0, 4'd1);
        tick(8);
        crd = 3'b010;
        tick(10);
        crd = 3'b011;
        tick(10);
        chk("frozen", 1'b1, 1'b0, 4'd1);
        crd = 3'b001;
        tick(15);
        chk("restart", 1'b1, 1'b0, 4'd1);
        tick(1);
        chk("drain3", 1'b0, 1'b0, 4'd0);
        tick(20);
        chk("empty_green", 1'b0, 1'b0, 4'd0);

        // saturation under RED
        crd = 3'b100;
        for (int i = 0; i < 20; i++) begin
            car();
            chk("saturate", 1'b1, 1'b0, (i < 15) ? 4'(i + 1) : 4'd15);
        end

        // arrival coinciding with a drain pulse
        crd = 3'b001;
        tick(16);
        chk("sim_drain", 1'b1, 1'b0, 4'd14);
        tick(6);
        sensor_raw = 1'b1;
        tick(9);
        chk("sim_pre", 1'b1, 1'b0, 4'd14);
        tick(1);
        chk("sim_both", 1'b1, 1'b1, 4'd14);
        tick(8);
        sensor_raw = 1'b0;
        tick(8);
        chk("sim_after", 1'b1, 1'b1, 4'd13);
        crd = 3'b100;
        tick(4);

        // reset during FALL_CHK with five cars queued
        clear_n = 1'b0;
        tick(1);
        clear_n = 1'b1;
        chk("clear", 1'b0, 1'b0, 4'd0);
        for (int i = 0; i < 4; i++) car();
        chk("queue4", 1'b1, 1'b0, 4'd4);
        sensor_raw = 1'b1;
        tick(12);
        chk("queue5", 1'b1, 1'b1, 4'd5);
        sensor_raw = 1'b0;
        tick(4);
        chk("fall_chk", 1'b1, 1'b1, 4'd5);
        sensor_raw = 1'b1;
        clear_n    = 1'b0;
        tick(1);
        chk("mid_reset", 1'b0, 1'b0, 4'd0);
        clear_n = 1'b1;
        tick(9);
        chk("redetect_pre", 1'b0, 1'b0, 4'd0);
        tick(1);
        chk("redetect", 1'b1, 1'b1, 4'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
